// File: rtl/dpd_coef_bank_ctrl_pkg.sv
// Shared types and sizes for the DPD coefficient ping-pong bank controller.
// 3 taps x 5 orders = 15 complex coefficients, 20-bit I and Q.
package dpd_coef_bank_ctrl_pkg;

    localparam int unsigned N_COEF = 15;
    localparam int unsigned W_COEF = 20;

    typedef logic [3:0]        u4;
    typedef logic [W_COEF-1:0] u20;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        COPY
    } state_e;

    function automatic logic idx_ok(u4 idx);
        return 32'(idx) < N_COEF;
    endfunction

endpackage

// File: rtl/dpd_coef_bank_ctrl_if.sv
// Active coefficient set handed from the bank controller to the DPD datapath.
// master drives the set, slave (datapath) consumes it.
interface intf_coef_3_5;
    import dpd_coef_bank_ctrl_pkg::*;

    u20 i [N_COEF];
    u20 q [N_COEF];

    modport master (output i, output q);
    modport slave  (input  i, input  q);

endinterface

// File: rtl/dpd_coef_regbank.sv
// One coefficient bank: N_COEF x (I,Q) registers, single write port,
// every entry readable in parallel.
module dpd_coef_regbank
    import dpd_coef_bank_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic we,
    input  u4    widx,
    input  u20   wi,
    input  u20   wq,
    output u20   rd_i [N_COEF],
    output u20   rd_q [N_COEF]
);

    u20 mem_i [N_COEF];
    u20 mem_q [N_COEF];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N_COEF; k++) begin
                mem_i[k] <= '0;
                mem_q[k] <= '0;
            end
        end else if (we && idx_ok(widx)) begin
            mem_i[widx] <= wi;
            mem_q[widx] <= wq;
        end
    end

    assign rd_i = mem_i;
    assign rd_q = mem_q;

endmodule

// File: rtl/dpd_coef_bank_ctrl.sv
// Ping-pong DPD coefficient controller: host fills the shadow bank, commit arms a
// swap on the next frame sync, then the new active set is copied back to shadow.
// Optional ARMED watchdog with forced swap: define DPD_COEF_TIMEOUT_EN.
module dpd_coef_bank_ctrl
    import dpd_coef_bank_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  u4           wr_idx,
    input  u20          wr_i,
    input  u20          wr_q,
    input  logic        commit,
    input  logic        sync,
    intf_coef_3_5.master coef,
    output logic        busy,
    output logic        swap_done,
    output logic        active_bank,
    output logic        err
);

    state_e state_q, state_d;
    u4      cnt_q, cnt_d;
    logic   bank_q, bank_d;
    logic   err_q, err_d;
    logic   done_q, done_d;
    logic   swap;
    logic   tmo_hit;

    u20 coef_i_q [N_COEF];
    u20 coef_q_q [N_COEF];

    u20 b0_i [N_COEF];
    u20 b0_q [N_COEF];
    u20 b1_i [N_COEF];
    u20 b1_q [N_COEF];
    u20 act_i [N_COEF];
    u20 act_q [N_COEF];
    u20 shd_i [N_COEF];
    u20 shd_q [N_COEF];

    logic bank_we;
    u4    bank_widx;
    u20   bank_wi;
    u20   bank_wq;

    // Bank bank_q drives the datapath; the other one is the shadow.
    always_comb begin
        for (int k = 0; k < N_COEF; k++) begin
            if (bank_q) begin
                act_i[k] = b1_i[k];
                act_q[k] = b1_q[k];
                shd_i[k] = b0_i[k];
                shd_q[k] = b0_q[k];
            end else begin
                act_i[k] = b0_i[k];
                act_q[k] = b0_q[k];
                shd_i[k] = b1_i[k];
                shd_q[k] = b1_q[k];
            end
        end
    end

`ifdef DPD_COEF_TIMEOUT_EN
    logic [15:0] tmo_q;

    assign tmo_hit = (state_q == ARMED) && (32'(tmo_q) + 32'd1 >= TIMEOUT_CYC);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q <= '0;
        end else if (state_q == ARMED && state_d == ARMED) begin
            tmo_q <= tmo_q + 16'd1;
        end else begin
            tmo_q <= '0;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bank_d    = bank_q;
        err_d     = err_q;
        done_d    = 1'b0;
        swap      = 1'b0;
        bank_we   = 1'b0;
        bank_widx = wr_idx;
        bank_wi   = wr_i;
        bank_wq   = wr_q;
        unique case (state_q)
            IDLE: begin
                bank_we = wr_valid && idx_ok(wr_idx);
                if (commit) begin
                    state_d = ARMED;
                    err_d   = 1'b0;
                end
                // An out-of-range write wins over the commit's err clear.
                if (wr_valid && !idx_ok(wr_idx)) begin
                    err_d = 1'b1;
                end
            end
            ARMED: begin
                if (commit) begin
                    err_d = 1'b1;
                end
                if (sync || tmo_hit) begin
                    swap    = 1'b1;
                    state_d = COPY;
                    cnt_d   = '0;
                    bank_d  = ~bank_q;
                    if (!sync) begin
                        err_d = 1'b1;
                    end
                end
            end
            COPY: begin
                if (commit) begin
                    err_d = 1'b1;
                end
                bank_we   = 1'b1;
                bank_widx = cnt_q;
                bank_wi   = act_i[cnt_q];
                bank_wq   = act_q[cnt_q];
                if (cnt_q == u4'(N_COEF - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + u4'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bank_q  <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            for (int k = 0; k < N_COEF; k++) begin
                coef_i_q[k] <= '0;
                coef_q_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bank_q  <= bank_d;
            err_q   <= err_d;
            done_q  <= done_d;
            if (swap) begin
                for (int k = 0; k < N_COEF; k++) begin
                    coef_i_q[k] <= shd_i[k];
                    coef_q_q[k] <= shd_q[k];
                end
            end
        end
    end

    dpd_coef_regbank u_bank0 (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (bank_we && bank_q),
        .widx    (bank_widx),
        .wi      (bank_wi),
        .wq      (bank_wq),
        .rd_i    (b0_i),
        .rd_q    (b0_q)
    );

    dpd_coef_regbank u_bank1 (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (bank_we && !bank_q),
        .widx    (bank_widx),
        .wi      (bank_wi),
        .wq      (bank_wq),
        .rd_i    (b1_i),
        .rd_q    (b1_q)
    );

    for (genvar k = 0; k < N_COEF; k++) begin : g_out
        assign coef.i[k] = coef_i_q[k];
        assign coef.q[k] = coef_q_q[k];
    end

    assign wr_ready    = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign swap_done   = done_q;
    assign active_bank = bank_q;
    assign err         = err_q;

endmodule
